// File: rtl/mem_defs.sv
// rtl/mem_defs.sv - shared definitions for the memory-stage access controller
// Purpose: FSM state encoding, timeout default and the data returned on an
//          abandoned access.
package mem_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    localparam int          TO_CYCLES_DEFAULT = 16;
    localparam logic [31:0] ERR_DATA          = 32'h0;

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - BUSY-cycle counter with terminal-count flag
// Purpose: counts cycles spent waiting for mem_ack; tc_o flags the last
//          permitted wait cycle (count == LIMIT-1).
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous active-low reset
//   clr_i  in  synchronous clear (has priority over en_i)
//   en_i   in  count enable
//   tc_o   out terminal count reached
module mem_timeout_ctr #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - M-stage data memory access controller
// Purpose: turns M-stage load/store requests into a req/ack handshake with a
//          multi-cycle data memory, stalls the pipeline until the access
//          finishes and flags misaligned, timed-out and illegal accesses.
// Ports:
//   clk, reset            clock / asynchronous active-low reset
//   MemReadM, MemWriteM   M-stage load / store
//   ALUOutM, WriteDataM   byte address / store data
//   ReadDataM             load data (capture register)
//   StallM                freeze F..M this cycle
//   MemErrM               error pulse for the current M instruction
//   mem_req, mem_we       request / write strobe to data memory
//   mem_addr, mem_wdata   registered address / write data
//   mem_ack, mem_rdata    one-cycle completion / read data from memory
module mem_access_ctrl
    import mem_defs::*;
#(
    parameter int WIDTH     = 32,
    parameter int TO_CYCLES = TO_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemReadM,
    input  logic             MemWriteM,
    input  logic [WIDTH-1:0] ALUOutM,
    input  logic [WIDTH-1:0] WriteDataM,
    output logic [WIDTH-1:0] ReadDataM,
    output logic             StallM,
    output logic             MemErrM,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
);

    mem_state_e       state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    // Pending error for the DONE cycle: illegal access or timeout.
    logic             err_q, err_d;

    logic access;
    logic aligned;
    logic accept;
    logic ctr_clr;
    logic ctr_en;
    logic ctr_tc;

    assign access  = MemReadM | MemWriteM;
    assign aligned = (ALUOutM[1:0] == 2'b00);

    mem_timeout_ctr #(
        .LIMIT (TO_CYCLES)
    ) u_timeout_ctr (
        .clk   (clk),
        .reset (reset),
        .clr_i (ctr_clr),
        .en_i  (ctr_en),
        .tc_o  (ctr_tc)
    );

    always_comb begin
        state_d = state_q;
        StallM  = 1'b0;
        MemErrM = 1'b0;
        mem_req = 1'b0;
        accept  = 1'b0;
        ctr_clr = 1'b0;
        ctr_en  = 1'b0;
        cap_d   = cap_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    if (aligned) begin
                        StallM  = 1'b1;
                        accept  = 1'b1;
                        ctr_clr = 1'b1;
                        // Read+write together is carried out as a write but
                        // still reported once the access has finished.
                        err_d   = MemReadM & MemWriteM;
                        state_d = ST_BUSY;
                    end else begin
                        // Misaligned: no request, pipeline is allowed to move.
                        MemErrM = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                mem_req = 1'b1;
                StallM  = 1'b1;
                ctr_en  = 1'b1;
                // An ack on the limit cycle wins over the timeout.
                if (mem_ack) begin
                    if (!we_q) begin
                        cap_d = mem_rdata;
                    end
                    state_d = ST_DONE;
                end else if (ctr_tc) begin
                    cap_d   = WIDTH'(ERR_DATA);
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                MemErrM = err_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request fields are captured only on acceptance so they stay stable
    // for the whole BUSY window.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        if (accept) begin
            addr_d  = ALUOutM;
            wdata_d = WriteDataM;
            we_d    = MemWriteM;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            cap_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            cap_q   <= cap_d;
            err_q   <= err_d;
        end
    end

    assign ReadDataM = cap_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;

    logic        clk;
    logic        reset;
    logic        MemReadM;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        MemErrM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    mem_access_ctrl #(
        .WIDTH     (32),
        .TO_CYCLES (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MemErrM    (MemErrM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          stall;
        int          req;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        we;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   stall_cnt = 0;
    int   req_cnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: retires one scoreboard entry per M instruction that leaves
    // the stage (access present and no stall).
    always @(negedge clk) begin
        if (!reset) begin
            stall_cnt = 0;
            req_cnt   = 0;
        end else begin
            if (StallM && MemErrM) chk("stall_with_err", 32'(StallM & MemErrM), 32'd0);
            if (mem_req) begin
                req_cnt++;
                if (exp_q.size() > 0) begin
                    chk("req_addr", mem_addr, exp_q[0].addr);
                    chk("req_wdata", mem_wdata, exp_q[0].wd);
                    chk("req_we", 32'(mem_we), 32'(exp_q[0].we));
                end
            end
            if (MemReadM || MemWriteM) begin
                if (StallM) begin
                    stall_cnt++;
                end else if (exp_q.size() == 0) begin
                    chk("unexpected_retire", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("ReadDataM", ReadDataM, e.rd);
                    chk("MemErrM", 32'(MemErrM), 32'(e.err));
                    chk("stall_cycles", 32'(stall_cnt), 32'(e.stall));
                    chk("req_cycles", 32'(req_cnt), 32'(e.req));
                    stall_cnt = 0;
                    req_cnt   = 0;
                end
            end
        end
    end

    // Presents one M instruction and plays the memory side. wait_n is the
    // index of the BUSY cycle that carries the ack.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdv,
                         input int wait_n, input bit no_ack,
                         input logic [31:0] exp_rd, input bit exp_err,
                         input int exp_stall, input int exp_req);
        exp_t e;
        int   req_idx;
        bit   retired;
        bit   done;
        e.rd = exp_rd; e.err = exp_err; e.stall = exp_stall; e.req = exp_req;
        e.addr = addr; e.wd = wd; e.we = wr;
        exp_q.push_back(e);
        MemReadM   = rd;
        MemWriteM  = wr;
        ALUOutM    = addr;
        WriteDataM = wd;
        req_idx    = 0;
        done       = 1'b0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            if (mem_req && !no_ack && req_idx == wait_n) begin
                mem_ack   = 1'b1;
                mem_rdata = rdv;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'h5A5A_5A5A;
            end
            if (mem_req) req_idx++;
            @(negedge clk);
            retired = !StallM;
            @(posedge clk);
            #1;
            if (retired) done = 1'b1;
        end
        if (!done) chk("issue_timeout", 32'd0, 32'd1);
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
        mem_ack   = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        ALUOutM    = 32'h0;
        WriteDataM = 32'h0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_ReadDataM", ReadDataM, 32'h0);
        chk("rst_StallM", 32'(StallM), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 1: load, ack first BUSY cycle
        issue(1, 0, 32'h100, 32'h0, 32'hCAFE_F00D, 0, 0, 32'hCAFE_F00D, 0, 2, 1);
        // 2: store, ack after 4 waits; rdata on ack must not be captured
        issue(0, 1, 32'h204, 32'h1234_5678, 32'hFFFF_0000, 4, 0, 32'hCAFE_F00D, 0, 6, 5);
        // 3: misaligned load
        issue(1, 0, 32'h102, 32'h0, 32'h0, 0, 0, 32'hCAFE_F00D, 1, 0, 0);
        // illegal read+write: executed as write, error in DONE
        issue(1, 1, 32'h20, 32'hA5A5_A5A5, 32'hFFFF_0000, 0, 0, 32'hCAFE_F00D, 1, 2, 1);
        // 4: load with no ack -> timeout after 16 BUSY cycles
        issue(1, 0, 32'h80, 32'h0, 32'h0, 0, 1, 32'h0, 1, 17, 16);
        // ack exactly on the limit cycle counts as success
        issue(1, 0, 32'h84, 32'h0, 32'h1111_2222, 15, 0, 32'h1111_2222, 0, 17, 16);

        // 5: reset in the middle of BUSY
        MemReadM = 1'b1;
        ALUOutM  = 32'h300;
        @(posedge clk);
        #1;
        chk("t5_req_busy", 32'(mem_req), 32'd1);
        reset     = 1'b0;
        MemReadM  = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("t5_req_drop", 32'(mem_req), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_idle_req", 32'(mem_req), 32'd0);
        chk("t5_stale_ack", ReadDataM, 32'h0);
        mem_ack = 1'b0;
        @(posedge clk);
        #1;
        issue(1, 0, 32'h40, 32'h0, 32'h0BAD_F00D, 1, 0, 32'h0BAD_F00D, 0, 3, 2);

        // 6: back-to-back loads
        issue(1, 0, 32'h10, 32'h0, 32'hAAAA_0010, 0, 0, 32'hAAAA_0010, 0, 2, 1);
        issue(1, 0, 32'h14, 32'h0, 32'hBBBB_0014, 2, 0, 32'hBBBB_0014, 0, 4, 3);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
